xfire_fpu_bkm_norm: RTL and testbench

XFIRE_FPU_BKM_NORM -- requirements
Module: xfire_fpu_bkm_norm

---
 rtl/xfire_fpu_bkm_norm_if.sv | 26 ++
 rtl/xfire_fpu_bkm_norm.sv | 82 ++++++++
 tb/tb_xfire_fpu_bkm_norm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/xfire_fpu_bkm_norm_if.sv
// Handshake and data bundle for the BKM result normaliser: an upstream word
// channel and a downstream normalised-result channel.
interface xfire_fpu_bkm_norm_if #(
  parameter int W = 32,
  parameter int E = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mant;
  logic [E-1:0] out_exp;
  logic         out_zero;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mant, out_exp, out_zero
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mant, out_exp, out_zero
  );
endinterface

// File: rtl/xfire_fpu_bkm_norm.sv
// Sign/magnitude normaliser for signed BKM results: left-justifies |in_data|
// and reports the shift count. Define XFIRE_FPU_BKM_NORM_FAST_EN to skip zero nibbles.
module xfire_fpu_bkm_norm #(
  parameter int W = 32,
  parameter int E = 6
) (
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 enable,
  xfire_fpu_bkm_norm_if.slave  bus
);

  if (W < 8 || W > 64 || E < $clog2(W) + 1) begin : g_param_check
    $error("xfire_fpu_bkm_norm: illegal W/E combination");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]   state;
  logic         sign_q;
  logic         zero_q;
  logic [W-1:0] mag_q;
  logic [E-1:0] exp_q;
  logic [W-1:0] abs_in;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    abs_in = bus.in_data;
    if (bus.in_data[W-1]) abs_in = ~bus.in_data + W'(1);
  end

  assign bus.in_ready  = (state == IDLE) && enable;
  assign bus.out_valid = (state == DONE) && enable;
  assign bus.out_sign  = sign_q;
  assign bus.out_mant  = mag_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_zero  = zero_q;

  // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      mag_q  <= '0;
      exp_q  <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.in_data[W-1];
            mag_q  <= abs_in;
            exp_q  <= '0;
            zero_q <= (abs_in == '0);
            state  <= (abs_in == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (mag_q[W-1]) begin
            state <= DONE;
`ifdef XFIRE_FPU_BKM_NORM_FAST_EN
          end else if (mag_q[W-1 -: 4] == 4'd0) begin
            // A whole zero nibble at the top can go in one step; exp stays below W.
            mag_q <= mag_q << 4;
            exp_q <= exp_q + E'(4);
`endif
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q + E'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xfire_fpu_bkm_norm.sv
// Directed bench for xfire_fpu_bkm_norm: scoreboard of expected results and
// latencies, with handshake stall, enable-freeze and mid-operation reset cases.
module tb_xfire_fpu_bkm_norm;
  localparam int W = 32;
  localparam int E = 6;

  logic clk    = 1'b0;
  logic srst_n = 1'b0;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  xfire_fpu_bkm_norm_if #(.W(W), .E(E)) bus ();

  xfire_fpu_bkm_norm #(.W(W), .E(E)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .enable (enable),
    .bus    (bus)
  );

  typedef struct {
    logic         sign;
    logic [W-1:0] mant;
    logic [E-1:0] exp;
    logic         zero;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t         r;
    logic [W-1:0] m;
    int           lz;
    m = d;
    if (d[W-1]) m = 0 - d;
    lz = W;
    for (int i = 0; i < W; i++) if (m[i]) lz = W - 1 - i;
    r.zero = (m == 0);
    r.sign = d[W-1];
    r.mant = r.zero ? '0 : (m << lz);
    r.exp  = r.zero ? '0 : E'(lz);
`ifdef XFIRE_FPU_BKM_NORM_FAST_EN
    r.lat  = r.zero ? 1 : (lz / 4 + lz % 4 + 2);
`else
    r.lat  = r.zero ? 1 : (lz + 2);
`endif
    return r;
  endfunction

  // One word through the block; hold = DONE stall cycles with in_valid kept high,
  // drop_at = latency count at which enable is dropped for 4 edges (-1: never).
  task automatic run_op(input logic [W-1:0] d, input int hold, input int drop_at, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    @(negedge clk);
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    e = model(d);
    if (drop_at >= 0) e.lat += 4;
    sb.push_back(e);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    n = 1;
    #1;
    bus.in_data  = ~d;
    bus.in_valid = (hold > 0);
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      if (drop_at >= 0) enable = !(n >= drop_at && n < drop_at + 4);
      @(posedge clk);
      n++;
      #1;
    end
    enable = 1'b1;
    got = sb.pop_front();
    if (!bus.out_valid) begin
      check({tag, " timeout"}, 64'(0), 64'(1));
      bus.in_valid = 1'b0;
      return;
    end
    check({tag, " latency"}, 64'(n), 64'(got.lat));
    check({tag, " sign"}, 64'(bus.out_sign), 64'(got.sign));
    check({tag, " mant"}, 64'(bus.out_mant), 64'(got.mant));
    check({tag, " exp"},  64'(bus.out_exp),  64'(got.exp));
    check({tag, " zero"}, 64'(bus.out_zero), 64'(got.zero));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 64'(bus.out_valid), 64'(1));
      check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'(0));
      check({tag, " hold mant"}, 64'(bus.out_mant), 64'(got.mant));
      check({tag, " hold exp"}, 64'(bus.out_exp), 64'(got.exp));
      check({tag, " hold sign"}, 64'(bus.out_sign), 64'(got.sign));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " post valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, " post idle"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b0;
    if (hold > 0) begin
      @(posedge clk);
      #1;
      check({tag, " no recapture"}, 64'(bus.in_ready), 64'(1));
      check({tag, " no recapture valid"}, 64'(bus.out_valid), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    srst_n = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 64'(bus.out_valid), 64'(0));
    check("rst in_ready", 64'(bus.in_ready), 64'(1));
    check("rst mant", 64'(bus.out_mant), 64'(0));
    check("rst exp", 64'(bus.out_exp), 64'(0));
    check("rst sign", 64'(bus.out_sign), 64'(0));
    check("rst zero", 64'(bus.out_zero), 64'(0));
    @(negedge clk);
    srst_n = 1'b1;

    run_op(32'h4000_0000, 0, -1, "pos_half");
    run_op(32'hFFFF_FFFF, 0, -1, "minus_one");
    run_op(32'h8000_0000, 0, -1, "most_neg");
    run_op(32'h0000_0000, 0, -1, "zero");
    run_op(32'h0000_0001, 0, -1, "plus_one");
    run_op(32'h7FFF_FFFF, 0, -1, "most_pos");
    run_op(32'h0000_1234, 5, -1, "stall");
    run_op(32'hFFFF_FFFF, 0, 2, "enable_drop");

    // Reset in the middle of a long normalisation must abort it silently.
    @(negedge clk);
    bus.in_data   = 32'hFFFF_FFFF;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst in_ready", 64'(bus.in_ready), 64'(1));
    check("mid_rst mant", 64'(bus.out_mant), 64'(0));
    check("mid_rst exp", 64'(bus.out_exp), 64'(0));
    check("mid_rst sign", 64'(bus.out_sign), 64'(0));
    check("mid_rst zero", 64'(bus.out_zero), 64'(0));
    @(negedge clk);
    srst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst no output", 64'(bus.out_valid), 64'(0));

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] r;
      r = $urandom >> $urandom_range(0, 31);
      if (i % 2 == 1) r = 0 - r;
      run_op(r, 0, -1, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
